// File: rtl/dmem_arb_pkg.sv
// Shared types and the request/grant mux for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int ARB_AW = 9;
    localparam int ARB_DW = 32;

    typedef enum logic {
        ARB_CORE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    // Request struct widths follow the package defaults; the top's address and
    // data parameters must match them.
    typedef struct packed {
        logic              we;
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] wdata;
        logic [2:0]        func3;
    } dmem_req_t;

    // Selects which requester drives the memory port this cycle.
    function automatic dmem_req_t arb_grant_mux(input logic      sel_dbg,
                                                input dmem_req_t core,
                                                input dmem_req_t dbg);
        return sel_dbg ? dbg : core;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_counter.sv
// Saturating up-counter with clear priority; used for dbg starvation and
// lock-window beat counting.
module arb_sat_counter #(
    parameter int MAX = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       inc,
    output logic [$clog2(MAX+1)-1:0]   cnt
);

    localparam int W = $clog2(MAX + 1);

    // Clear wins over increment; holds at MAX.
    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (inc && (cnt != W'(MAX)))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between the MEM-stage core access and
// a valid/ready debug/loader port. The core has priority; dbg takes idle
// slots. Define DMEM_ARB_FAIRNESS_EN to add a starvation-triggered dbg lock
// window that stalls the pipeline.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = ARB_AW,
    parameter int DATA_W     = ARB_DW,
    parameter int MAX_WAIT   = 15,
    parameter int LOCK_BEATS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_func3,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,
    input  logic                  dbg_valid,
    output logic                  dbg_ready,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [2:0]            dbg_func3,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    dmem_req_t         core_r, dbg_r, gnt;
    logic              in_lock;
    logic              accept;
    logic              core_access;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(LOCK_BEATS + 1);

    arb_state_t    state, state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] beat_cnt;
    logic          lock_exit;

    assign in_lock    = (state == ARB_LOCK);
    assign core_stall = !reset && in_lock && core_req;

    arb_sat_counter #(.MAX(MAX_WAIT)) u_starve (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .inc   (dbg_valid && !dbg_ready),
        .cnt   (starve_cnt)
    );

    arb_sat_counter #(.MAX(LOCK_BEATS)) u_beat (
        .clk   (clk),
        .reset (reset),
        .clr   (lock_exit),
        .inc   (in_lock && accept),
        .cnt   (beat_cnt)
    );

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= ARB_CORE;
        else
            state <= state_nxt;
    end

    // Enter the lock once dbg has starved long enough; leave when dbg goes
    // idle or the window's beat budget is used up.
    always_comb begin
        state_nxt = state;
        lock_exit = 1'b0;
        case (state)
            ARB_CORE: begin
                if ((starve_cnt == SW'(MAX_WAIT)) && dbg_valid)
                    state_nxt = ARB_LOCK;
            end
            ARB_LOCK: begin
                if (!dbg_valid || (accept && (beat_cnt == BW'(LOCK_BEATS - 1)))) begin
                    state_nxt = ARB_CORE;
                    lock_exit = 1'b1;
                end
            end
            default: state_nxt = ARB_CORE;
        endcase
    end
`else
    localparam int unused_cfg = MAX_WAIT + LOCK_BEATS;

    assign in_lock    = 1'b0;
    assign core_stall = 1'b0;
`endif

    // Pack both requesters for the grant mux.
    always_comb begin
        core_r = '{we: core_we, addr: core_addr, wdata: core_wdata, func3: core_func3};
        dbg_r  = '{we: dbg_we,  addr: dbg_addr,  wdata: dbg_wdata,  func3: dbg_func3};
    end

    // Dbg is accepted whenever it owns the port; all grants are masked in reset.
    always_comb begin
        dbg_ready = 1'b0;
        if (!reset)
            dbg_ready = in_lock ? dbg_valid : (dbg_valid && !core_req);
    end

    assign accept      = dbg_ready;
    assign core_access = !reset && !in_lock && !dbg_ready && core_req;
    assign gnt         = arb_grant_mux(dbg_ready || in_lock, core_r, dbg_r);

    assign mem_rd     = (accept || core_access) && !gnt.we;
    assign mem_wr     = (accept || core_access) &&  gnt.we;
    assign mem_addr   = gnt.addr;
    assign mem_wdata  = gnt.wdata;
    assign mem_func3  = gnt.func3;
    assign core_rdata = mem_rdata;

    // Capture dbg read data on the accept edge; rvalid pulses the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= accept && !dbg_we;
            if (accept && !dbg_we)
                rdata_q <= mem_rdata;
        end
    end

    // A response pending when reset arrives is dropped immediately.
    assign dbg_rvalid = rvalid_q && !reset;
    assign dbg_rdata  = reset ? '0 : rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed vector table, lock
// corner sequences and randomized traffic against a cycle reference model.
module tb_dmem_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MAX_WAIT = 15;
    localparam int LOCK_BEATS = 4;
`ifdef DMEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we, core_stall;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic [2:0]    core_func3;
    logic          dbg_valid, dbg_ready, dbg_we, dbg_rvalid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic [2:0]    dbg_func3;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [2:0]    mem_func3;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_func3(core_func3),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_func3(dbg_func3),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
    );

    // Bench-side data memory, combinational read.
    logic [DW-1:0] tmem [512];
    assign mem_rdata = tmem[mem_addr];

    // Reference model state.
    logic [DW-1:0] mmem [512];
    bit            m_lock, m_rv;
    int            m_wait, m_beats;
    logic [DW-1:0] m_rdata;

    // Model expectations for the current cycle.
    logic          e_ready, e_stall, e_rd, e_wr, e_core_rd, e_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic [2:0]    e_func3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic          w_en;
    logic [AW-1:0] w_a;
    logic [DW-1:0] w_d;

    typedef struct {
        bit rst, cr, cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        bit dv, dwe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwd;
        bit x_ready, x_stall, x_rd, x_wr;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wdata;
        bit x_rv;
        logic [DW-1:0] x_rdata;
    } vec_t;

    vec_t vt [14];

    function automatic vec_t mkv(bit rst, bit cr, bit cwe, logic [AW-1:0] caddr, logic [DW-1:0] cwd,
                                 bit dv, bit dwe, logic [AW-1:0] daddr, logic [DW-1:0] dwd,
                                 bit xr, bit xs, bit xrd, bit xwr, logic [AW-1:0] xa,
                                 logic [DW-1:0] xwd, bit xrv, logic [DW-1:0] xrdata);
        vec_t v;
        v.rst = rst; v.cr = cr; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dv = dv; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
        v.x_ready = xr; v.x_stall = xs; v.x_rd = xrd; v.x_wr = xwr;
        v.x_addr = xa; v.x_wdata = xwd; v.x_rv = xrv; v.x_rdata = xrdata;
        return v;
    endfunction

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Expected outputs from the arbitration rules and current model state.
    task automatic model_comb();
        e_ready = 0; e_stall = 0; e_rd = 0; e_wr = 0; e_core_rd = 0;
        e_addr = '0; e_wdata = '0; e_func3 = '0;
        if (!reset) begin
            if (m_lock) begin
                e_ready = dbg_valid;
                e_stall = core_req;
            end else begin
                e_ready = dbg_valid && !core_req;
            end
            if (e_ready) begin
                e_rd = !dbg_we; e_wr = dbg_we;
                e_addr = dbg_addr; e_wdata = dbg_wdata; e_func3 = dbg_func3;
            end else if (!m_lock && core_req) begin
                e_rd = !core_we; e_wr = core_we; e_core_rd = !core_we;
                e_addr = core_addr; e_wdata = core_wdata; e_func3 = core_func3;
            end
        end
        e_rv    = !reset && m_rv;
        e_rdata = reset ? '0 : m_rdata;
    endtask

    task automatic check_all();
        chkb("dbg_ready", dbg_ready, e_ready);
        chkb("core_stall", core_stall, e_stall);
        chkb("mem_rd", mem_rd, e_rd);
        chkb("mem_wr", mem_wr, e_wr);
        chkb("dbg_rvalid", dbg_rvalid, e_rv);
        chkw("dbg_rdata", dbg_rdata, e_rdata);
        if (e_rd || e_wr) begin
            chkw("mem_addr", 32'(mem_addr), 32'(e_addr));
            chkw("mem_func3", 32'(mem_func3), 32'(e_func3));
        end
        if (e_wr) chkw("mem_wdata", mem_wdata, e_wdata);
        if (e_core_rd) chkw("core_rdata", core_rdata, mmem[e_addr]);
    endtask

    // Advance the model across one clock edge.
    task automatic model_update();
        if (reset) begin
            m_lock = 0; m_wait = 0; m_beats = 0; m_rv = 0; m_rdata = '0;
        end else begin
            m_rv = e_ready && !dbg_we;
            if (m_rv) m_rdata = mmem[dbg_addr];
            if (e_wr) mmem[e_addr] = e_wdata;
            if (FAIR) begin
                if (!m_lock) begin
                    if (m_wait == MAX_WAIT && dbg_valid) begin
                        m_lock = 1; m_beats = 0;
                    end
                end else if (!dbg_valid) begin
                    m_lock = 0; m_beats = 0;
                end else begin
                    m_beats++;
                    if (m_beats == LOCK_BEATS) begin
                        m_lock = 0; m_beats = 0;
                    end
                end
                if (e_ready) m_wait = 0;
                else if (dbg_valid && m_wait < MAX_WAIT) m_wait++;
            end
        end
    endtask

    task automatic edge_tail();
        w_en = mem_wr; w_a = mem_addr; w_d = mem_wdata;
        @(posedge clk);
        model_update();
        if (w_en === 1'b1) tmem[w_a] = w_d;
        cyc++;
        #1;
    endtask

    task automatic model_cycle();
        #2;
        model_comb();
        check_all();
        edge_tail();
    endtask

    task automatic drive(bit rst, bit cr, bit cwe, logic [AW-1:0] ca, logic [DW-1:0] cwd,
                         bit dv, bit dwe, logic [AW-1:0] da, logic [DW-1:0] dwd);
        reset = rst; core_req = cr; core_we = cwe; core_addr = ca; core_wdata = cwd;
        dbg_valid = dv; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd;
    endtask

    int  nstall, first_stall, naccept;
    bit  st_hist [32];
    bit  pend;
    int  busy_pct;

    initial begin
        for (int i = 0; i < 512; i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            tmem[i] = v;
            mmem[i] = v;
        end
        m_lock = 0; m_wait = 0; m_beats = 0; m_rv = 0; m_rdata = '0;
        core_func3 = 3'b010; dbg_func3 = 3'b001;
        drive(1, 0, 0, '0, '0, 0, 0, '0, '0);
        @(posedge clk);
        #1;

        // Directed vector table.
        vt[0]  = mkv(1, 0,0,9'h00,32'h0,       1,0,9'h10,32'h0,        0,0,0,0,9'h00,32'h0,       0,32'h0);
        vt[1]  = mkv(1, 0,0,9'h00,32'h0,       1,0,9'h10,32'h0,        0,0,0,0,9'h00,32'h0,       0,32'h0);
        vt[2]  = mkv(1, 0,0,9'h00,32'h0,       1,0,9'h10,32'h0,        0,0,0,0,9'h00,32'h0,       0,32'h0);
        vt[3]  = mkv(0, 0,0,9'h00,32'h0,       1,1,9'h10,32'hDEADBEEF, 1,0,0,1,9'h10,32'hDEADBEEF,0,32'h0);
        vt[4]  = mkv(0, 0,0,9'h00,32'h0,       1,0,9'h10,32'h0,        1,0,1,0,9'h10,32'h0,       0,32'h0);
        vt[5]  = mkv(0, 0,0,9'h00,32'h0,       0,0,9'h00,32'h0,        0,0,0,0,9'h00,32'h0,       1,32'hDEADBEEF);
        vt[6]  = mkv(0, 1,0,9'h20,32'h0,       1,0,9'h30,32'h0,        0,0,1,0,9'h20,32'h0,       0,32'hDEADBEEF);
        vt[7]  = mkv(0, 1,1,9'h21,32'h1234,    1,0,9'h30,32'h0,        0,0,0,1,9'h21,32'h1234,    0,32'hDEADBEEF);
        vt[8]  = mkv(0, 0,0,9'h00,32'h0,       1,0,9'h21,32'h0,        1,0,1,0,9'h21,32'h0,       0,32'hDEADBEEF);
        vt[9]  = mkv(0, 0,0,9'h00,32'h0,       0,0,9'h00,32'h0,        0,0,0,0,9'h00,32'h0,       1,32'h1234);
        vt[10] = mkv(0, 1,0,9'h10,32'h0,       1,0,9'h10,32'h0,        0,0,1,0,9'h10,32'h0,       0,32'h1234);
        vt[11] = mkv(0, 0,0,9'h00,32'h0,       1,0,9'h10,32'h0,        1,0,1,0,9'h10,32'h0,       0,32'h1234);
        vt[12] = mkv(1, 0,0,9'h00,32'h0,       0,0,9'h00,32'h0,        0,0,0,0,9'h00,32'h0,       0,32'h0);
        vt[13] = mkv(0, 0,0,9'h00,32'h0,       0,0,9'h00,32'h0,        0,0,0,0,9'h00,32'h0,       0,32'h0);

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].rst, vt[i].cr, vt[i].cwe, vt[i].caddr, vt[i].cwd,
                  vt[i].dv, vt[i].dwe, vt[i].daddr, vt[i].dwd);
            #2;
            chkb("tv_dbg_ready", dbg_ready, vt[i].x_ready);
            chkb("tv_core_stall", core_stall, vt[i].x_stall);
            chkb("tv_mem_rd", mem_rd, vt[i].x_rd);
            chkb("tv_mem_wr", mem_wr, vt[i].x_wr);
            chkb("tv_dbg_rvalid", dbg_rvalid, vt[i].x_rv);
            chkw("tv_dbg_rdata", dbg_rdata, vt[i].x_rdata);
            if (vt[i].x_rd || vt[i].x_wr) chkw("tv_mem_addr", 32'(mem_addr), 32'(vt[i].x_addr));
            if (vt[i].x_wr) chkw("tv_mem_wdata", mem_wdata, vt[i].x_wdata);
            model_comb();
            edge_tail();
        end

        // Core pinned busy, dbg streaming writes: starvation lock window.
        drive(1, 0, 0, '0, '0, 0, 0, '0, '0);
        model_cycle();
        nstall = 0; first_stall = -1; naccept = 0;
        drive(0, 1, 0, 9'h05, '0, 1, 1, 9'h40, 32'hA5A50000);
        for (int i = 0; i < 22; i++) begin
            #2;
            model_comb();
            check_all();
            if (core_stall === 1'b1) begin
                nstall++;
                if (first_stall < 0) first_stall = i;
            end
            if (dbg_ready === 1'b1) naccept++;
            edge_tail();
            if (e_ready) begin
                dbg_addr  = dbg_addr + 9'd1;
                dbg_wdata = dbg_wdata + 32'd1;
            end
        end
        chkw("lock_stall_cycles", 32'(nstall), FAIR ? 32'd4 : 32'd0);
        chkw("lock_first_stall", 32'(first_stall), FAIR ? 32'd16 : 32'hFFFFFFFF);
        chkw("lock_beats", 32'(naccept), FAIR ? 32'd4 : 32'd0);

        // Dbg goes idle two beats into the lock window.
        drive(1, 0, 0, '0, '0, 0, 0, '0, '0);
        model_cycle();
        naccept = 0;
        drive(0, 1, 0, 9'h06, '0, 1, 0, 9'h41, '0);
        for (int i = 0; i < 21; i++) begin
            if (i == 18) dbg_valid = 0;
            #2;
            model_comb();
            check_all();
            st_hist[i] = (core_stall === 1'b1);
            if (dbg_ready === 1'b1) naccept++;
            edge_tail();
        end
        chkb("early_exit_stall_next", st_hist[19], 1'b0);
        chkb("early_exit_stall_in_lock", st_hist[17], FAIR);
        chkw("early_exit_beats", 32'(naccept), FAIR ? 32'd2 : 32'd0);

        // Randomized traffic; dbg fields held until accepted.
        pend = 0;
        busy_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) busy_pct = $urandom_range(30, 100);
            reset      = ($urandom_range(0, 99) == 0);
            core_req   = ($urandom_range(0, 99) < busy_pct);
            core_we    = $urandom_range(0, 1);
            core_addr  = AW'($urandom_range(0, 31));
            core_wdata = $urandom;
            core_func3 = 3'($urandom_range(0, 7));
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend      = 1;
                dbg_we    = $urandom_range(0, 1);
                dbg_addr  = AW'($urandom_range(0, 31));
                dbg_wdata = $urandom;
                dbg_func3 = 3'($urandom_range(0, 7));
            end
            dbg_valid = pend;
            model_cycle();
            if (e_ready) pend = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
